// File: rtl/bcd_down_timer_if.sv
// Control/status bundle for the two-digit BCD countdown timer.
// The master drives preset and run control; the slave reports count and status.
interface bcd_down_timer_if;
   logic       load;
   logic [7:0] load_val;
   logic       start;
   logic       pause;
   logic [7:0] count;
   logic       busy;
   logic       done;

   modport master (
      output load, load_val, start, pause,
      input  count, busy, done
   );

   modport slave (
      input  load, load_val, start, pause,
      output count, busy, done
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer (99..00) with preset load, start/pause control
// and a one-cycle terminal pulse; all outputs come straight from registers.
module bcd_down_timer #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   bcd_down_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 32'd1);

   state_t      state_r;
   state_t      state_next_s;
   logic [7:0]  count_r;
   logic [7:0]  count_next_s;
   logic [7:0]  count_dec_s;
   logic [15:0] pre_r;
   logic [15:0] pre_next_s;
   logic        busy_r;
   logic        busy_next_s;
   logic        done_r;
   logic        done_next_s;

   function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
      return {tens, units};
   endfunction

   // Units borrow from tens; only ever applied to a nonzero count.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] != 4'd0) begin
         r = {v[7:4], v[3:0] - 4'd1};
      end else begin
         r = {v[7:4] - 4'd1, 4'd9};
      end
      return r;
   endfunction

   assign count_dec_s = bcd_dec(count_r);

   // Next-state, next-count and prescaler logic with load > pause > start > step priority.
   always_comb begin
      state_next_s = state_r;
      count_next_s = count_r;
      pre_next_s   = pre_r;
      done_next_s  = 1'b0;
      if (bus.load) begin
         count_next_s = bcd_clamp(bus.load_val);
         state_next_s = IDLE;
         pre_next_s   = 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  pre_next_s = 16'd0;
                  if (count_r != 8'h00) begin
                     state_next_s = RUN;
                  end else begin
                     state_next_s = DONE;
                     done_next_s  = 1'b1;
                  end
               end else begin
                  state_next_s = IDLE;
               end
            end
            RUN: begin
               if (bus.pause) begin
                  state_next_s = PAUSED;
               end else if (pre_r == PRE_LAST) begin
                  pre_next_s   = 16'd0;
                  count_next_s = count_dec_s;
                  if (count_dec_s == 8'h00) begin
                     state_next_s = DONE;
                     done_next_s  = 1'b1;
                  end else begin
                     state_next_s = RUN;
                  end
               end else begin
                  pre_next_s = pre_r + 16'd1;
               end
            end
            PAUSED: begin
               if (bus.start) begin
                  state_next_s = RUN;
               end else begin
                  state_next_s = PAUSED;
               end
            end
            DONE: begin
               count_next_s = 8'h00;
            end
            default: begin
               state_next_s = IDLE;
               count_next_s = 8'h00;
               pre_next_s   = 16'd0;
            end
         endcase
      end
      busy_next_s = (state_next_s == RUN) || (state_next_s == PAUSED);
   end

   // State, count, prescaler and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= 8'h00;
         pre_r   <= 16'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         count_r <= count_next_s;
         pre_r   <= pre_next_s;
         busy_r  <= busy_next_s;
         done_r  <= done_next_s;
      end
   end

   assign bus.count = count_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;

endmodule
